// File: rtl/vc_allocator_sep_pkg.sv
// Shared sizing, port naming and request-decoding helpers for the separable VC allocator.
package vc_allocator_sep_pkg;

  localparam int unsigned N  = 5;
  localparam int unsigned V  = 4;
  localparam int unsigned NV = N * V;
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned IW = $clog2(NV);

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_EAST  = 3'd1,
    P_SOUTH = 3'd2,
    P_WEST  = 3'd3,
    P_NORTH = 3'd4
  } port_e;

  typedef logic [N-1:0] port_oh_t;
  typedef logic [V-1:0] vc_mask_t;

  function automatic logic is_onehot(input port_oh_t p);
    return (p != '0) && ((p & (p - port_oh_t'(1))) == '0);
  endfunction

  function automatic logic [PW-1:0] port_idx(input port_oh_t p);
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (p[k]) idx = PW'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_allocator_sep_rr_arbiter.sv
// Round-robin W:1 arbiter with combinational one-hot grant; the registered pointer
// moves to one past the grant only when the caller confirms the grant was used.
module vc_allocator_sep_rr_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] req_i,
  input  logic         advance_i,
  output logic [W-1:0] grant_o
);

  localparam int unsigned PTRW = (W > 1) ? $clog2(W) : 1;

  logic [PTRW-1:0] ptr_q, ptr_d, gidx;
  logic [W-1:0]    hi_mask, masked, pick;

  // Prefer requesters at or above the pointer, else wrap to the lowest requester.
  always_comb begin
    hi_mask = ~((W'(1) << ptr_q) - W'(1));
    masked  = req_i & hi_mask;
    pick    = (masked != '0) ? masked : req_i;
    grant_o = pick & (~pick + W'(1));
  end

  always_comb begin
    gidx = '0;
    for (int k = 0; k < W; k++) begin
      if (grant_o[k]) gidx = PTRW'(k);
    end
    ptr_d = ptr_q;
    if (advance_i && (grant_o != '0)) begin
      ptr_d = (gidx == PTRW'(W - 1)) ? '0 : gidx + PTRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_allocator_sep.sv
// Separable input-first VC allocator: per-input V:1 pick, per-output NV:1 arbitration,
// zero-cycle grant; output VC busy/owner state held until the tail flit releases it.
module vc_allocator_sep
  import vc_allocator_sep_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [N*N*V-1:0]  req_port,
  input  logic [V*N*V-1:0]  req_vc,
  input  logic [N*V-1:0]    ovc_release,
  output logic [N*V-1:0]    vc_granted,
  output logic [V*N*V-1:0]  sel_out_vc,
  output logic [N*V-1:0]    ovc_busy,
  output logic              err_req
);

  logic [NV-1:0] busy_q, busy_d;
  logic [IW-1:0] owner_q [NV];
  logic [IW-1:0] owner_d [NV];
  logic          err_q, err_d;

  logic [NV-1:0] malformed;
  logic [PW-1:0] in_port [NV];
  vc_mask_t      elig    [NV];
  vc_mask_t      s1_gnt  [NV];
  logic [NV-1:0] s2_req  [NV];
  logic [NV-1:0] s2_gnt  [NV];
  logic [NV-1:0] s2_adv;

  // Eligibility uses registered busy only, so a VC released this cycle is not reusable until next.
  always_comb begin
    for (int i = 0; i < NV; i++) begin
      malformed[i] = (req_vc[i*V +: V] != '0) && !is_onehot(req_port[i*N +: N]);
      in_port[i]   = port_idx(req_port[i*N +: N]);
      elig[i]      = '0;
      if ((req_vc[i*V +: V] != '0) && is_onehot(req_port[i*N +: N])) begin
        elig[i] = req_vc[i*V +: V] & ~busy_q[in_port[i]*V +: V];
      end
    end
  end

  for (genvar i = 0; i < NV; i++) begin : g_s1
    vc_allocator_sep_rr_arbiter #(.W(V)) u_arb (
      .clk       (clk),
      .rstn      (rstn),
      .req_i     (elig[i]),
      .advance_i (vc_granted[i]),
      .grant_o   (s1_gnt[i])
    );
  end

  always_comb begin
    for (int o = 0; o < NV; o++) begin
      for (int i = 0; i < NV; i++) begin
        s2_req[o][i] = s1_gnt[i][o % V] && (in_port[i] == PW'(o / V));
      end
    end
  end

  for (genvar o = 0; o < NV; o++) begin : g_s2
    vc_allocator_sep_rr_arbiter #(.W(NV)) u_arb (
      .clk       (clk),
      .rstn      (rstn),
      .req_i     (s2_req[o]),
      .advance_i (s2_adv[o]),
      .grant_o   (s2_gnt[o])
    );
    assign s2_adv[o] = |s2_gnt[o];

    ap_owner_idle: assert property (@(posedge clk) disable iff (!rstn)
      !busy_q[o] |-> (owner_q[o] == '0));
  end

  always_comb begin
    vc_granted = '0;
    sel_out_vc = '0;
    for (int i = 0; i < NV; i++) begin
      for (int o = 0; o < NV; o++) begin
        if (s2_gnt[o][i]) vc_granted[i] = 1'b1;
      end
      if (vc_granted[i]) sel_out_vc[i*V +: V] = s1_gnt[i];
    end
  end

  // A grant needs busy=0 and an effective release needs busy=1, so the two never collide.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    err_d   = err_q | (|malformed);
    for (int o = 0; o < NV; o++) begin
      if (ovc_release[o] && busy_q[o]) begin
        busy_d[o]  = 1'b0;
        owner_d[o] = '0;
      end
      for (int i = 0; i < NV; i++) begin
        if (s2_gnt[o][i]) begin
          busy_d[o]  = 1'b1;
          owner_d[o] = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int o = 0; o < NV; o++) owner_q[o] <= '0;
    end else begin
      busy_q  <= busy_d;
      err_q   <= err_d;
      owner_q <= owner_d;
    end
  end

  assign ovc_busy = busy_q;
  assign err_req  = err_q;

endmodule

// File: tb/tb_vc_allocator_sep.sv
// Directed bench for vc_allocator_sep with hand-computed grant, busy and error expectations.
module tb_vc_allocator_sep;
  import vc_allocator_sep_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N*N*V-1:0] req_port;
  logic [V*N*V-1:0] req_vc;
  logic [N*V-1:0]   ovc_release;
  logic [N*V-1:0]   vc_granted;
  logic [V*N*V-1:0] sel_out_vc;
  logic [N*V-1:0]   ovc_busy;
  logic             err_req;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int order [4] = '{0, 4, 8, 0};

  vc_allocator_sep dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_port    (req_port),
    .req_vc      (req_vc),
    .ovc_release (ovc_release),
    .vc_granted  (vc_granted),
    .sel_out_vc  (sel_out_vc),
    .ovc_busy    (ovc_busy),
    .err_req     (err_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int port, input logic [V-1:0] vcm);
    req_port[i*N +: N] = port_oh_t'(1) << port;
    req_vc[i*V +: V]   = vcm;
  endtask

  task automatic clr_req(input int i);
    req_port[i*N +: N] = '0;
    req_vc[i*V +: V]   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_port    = '0;
    req_vc      = '0;
    ovc_release = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", ovc_busy, 0);
    check("rst_err", err_req, 0);
    check("rst_gnt", vc_granted, 0);
    check("rst_sel", sel_out_vc, 0);
    @(negedge clk) rstn = 1'b1;
    cyc();

    // Single request: input VC 0 -> port 2, candidates VC0/VC1
    set_req(0, 2, 4'b0011);
    #1;
    check("single_gnt", vc_granted, 20'h00001);
    check("single_sel", sel_out_vc, 128'h1);
    check("single_busy_pre", ovc_busy, 0);
    cyc();
    clr_req(0);
    check("single_busy", ovc_busy, 20'h00100);
    ovc_release[3] = 1'b1;
    cyc();
    ovc_release = '0;
    check("idle_rel_busy", ovc_busy, 20'h00100);
    check("idle_rel_err", err_req, 0);
    ovc_release[8] = 1'b1;
    cyc();
    ovc_release = '0;
    check("rel8_busy", ovc_busy, 0);

    // Contention for output VC 4
    set_req(4, 1, 4'b0001);
    set_req(12, 1, 4'b0001);
    #1;
    check("cont_gnt1", vc_granted, 20'h00010);
    check("cont_sel1", sel_out_vc, 128'(1) << 16);
    cyc();
    clr_req(4);
    #1;
    check("cont_busy", ovc_busy, 20'h00010);
    check("cont_blocked", vc_granted, 0);
    ovc_release[4] = 1'b1;
    #1;
    check("cont_rel_same_cyc", vc_granted, 0);
    cyc();
    ovc_release = '0;
    #1;
    check("cont_rel_busy", ovc_busy, 0);
    check("cont_gnt2", vc_granted, 20'h01000);
    check("cont_sel2", sel_out_vc, 128'(1) << 48);
    cyc();
    clr_req(12);
    check("cont_busy2", ovc_busy, 20'h00010);
    ovc_release[4] = 1'b1;
    cyc();
    ovc_release = '0;

    // Round-robin fairness on output VC 12
    set_req(0, 3, 4'b0001);
    set_req(4, 3, 4'b0001);
    set_req(8, 3, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), vc_granted, 128'(1) << order[k]);
      cyc();
      check($sformatf("rr_busy%0d", k), ovc_busy, 20'h01000);
      ovc_release[12] = 1'b1;
      #1;
      check($sformatf("rr_hold%0d", k), vc_granted, 0);
      cyc();
      ovc_release = '0;
    end
    clr_req(0);
    clr_req(4);
    clr_req(8);

    // Release and new request on output VC 8 in the same cycle
    set_req(1, 2, 4'b0001);
    #1;
    check("coll_gnt0", vc_granted, 20'h00002);
    check("coll_sel0", sel_out_vc, 128'(1) << 4);
    cyc();
    clr_req(1);
    check("coll_busy", ovc_busy, 20'h00100);
    set_req(2, 2, 4'b0001);
    ovc_release[8] = 1'b1;
    #1;
    check("coll_same_cyc", vc_granted, 0);
    cyc();
    ovc_release = '0;
    #1;
    check("coll_freed", ovc_busy, 0);
    check("coll_gnt1", vc_granted, 20'h00004);
    check("coll_sel1", sel_out_vc, 128'(1) << 8);
    cyc();
    clr_req(2);
    check("coll_busy2", ovc_busy, 20'h00100);
    ovc_release[8] = 1'b1;
    cyc();
    ovc_release = '0;

    // Malformed request: multi-hot port
    req_port[3*N +: N] = 5'b00110;
    req_vc[3*V +: V]   = 4'b0001;
    #1;
    check("bad_gnt", vc_granted, 0);
    check("bad_err_pre", err_req, 0);
    cyc();
    check("bad_err", err_req, 1);
    check("bad_busy", ovc_busy, 0);
    clr_req(3);
    cyc();
    check("bad_err_sticky", err_req, 1);

    // Asynchronous reset mid-operation
    set_req(0, 0, 4'b0001);
    #1;
    check("pre_rst_gnt", vc_granted, 20'h00001);
    cyc();
    clr_req(0);
    check("pre_rst_busy", ovc_busy, 20'h00001);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_busy", ovc_busy, 0);
    check("async_rst_err", err_req, 0);
    @(negedge clk) rstn = 1'b1;
    cyc();
    set_req(0, 3, 4'b0001);
    set_req(4, 3, 4'b0001);
    #1;
    check("rst_ptr_gnt", vc_granted, 20'h00001);
    cyc();
    clr_req(0);
    clr_req(4);
    ovc_release[12] = 1'b1;
    cyc();
    ovc_release = '0;
    rstn = 1'b0;
    cyc();
    @(negedge clk) rstn = 1'b1;
    cyc();

    // Full load: input i asks port i%5 with every VC as candidate
    for (int i = 0; i < NV; i++) set_req(i, i % N, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("load_gnt%0d", c), vc_granted, 128'(20'h1F) << (5 * c));
      for (int i = 0; i < NV; i++) begin
        check($sformatf("load_oh%0d_%0d", c, i), $countones(sel_out_vc[i*V +: V]), vc_granted[i]);
      end
      for (int i = 5 * c; i < 5 * c + 5; i++) begin
        check($sformatf("load_sel%0d_%0d", c, i), sel_out_vc[i*V +: V], 4'b0001 << c);
      end
      cyc();
      for (int i = 5 * c; i < 5 * c + 5; i++) clr_req(i);
    end
    check("load_busy", ovc_busy, 20'hFFFFF);
    set_req(0, 0, 4'b1111);
    #1;
    check("load_full_nogrant", vc_granted, 0);
    clr_req(0);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vc_allocator_sep.md
Name: vc_allocator_sep

Overview:
- Separable input-first virtual-channel allocator for the non-pipelined 5-port wormhole router.
- Collects VC requests from all N*V input VC controllers and grants at most one free output VC per input VC per cycle. Each output VC goes to at most one input VC.
- Tracks the busy/owner state of every output VC from allocation until the tail flit is released.
- Sits between the input VC controllers (reqPort/reqVC in, VCgranted/selOutVC out) and the switch allocator.

Parameters:
N, 5, number of router ports (`N)
V, 4, virtual channels per port (`V)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_port  in  N*N*V  per input VC i (i = port*V+vc), slice [i*N +: N]; one-hot requested output port
req_vc  in  V*N*V  per input VC i, slice [i*V +: V]; candidate output VC mask; all-zero means no request
release  in  N*V  per output VC o (o = port*V+vc); pulse when the owning tail flit wins SA
vc_granted  out  N*V  per input VC; grant this cycle
sel_out_vc  out  V*N*V  per input VC; one-hot granted VC of the requested port, zero when not granted
ovc_busy  out  N*V  registered busy flag per output VC
err_req  out  1  sticky; set on a malformed request

Behaviour:
- Reset (rstn low, asynchronous):
  - ovc_busy = 0; all owner registers = 0; err_req = 0.
  - All round-robin pointers = 0.
  - vc_granted = 0 and sel_out_vc = 0, because both depend on registered state and valid requests.
- Valid request: req_vc != 0 and req_port is one-hot.
- Malformed request: req_vc != 0 and req_port is zero or multi-hot.
  - The request is ignored.
  - err_req is set on the next edge and holds until reset.
- Stage 1 (input arbitration), one V:1 arbiter per input VC:
  - Eligible mask = req_vc & ~ovc_busy[port*V +: V].
  - A round-robin pick over that mask gives one candidate output VC.
- Stage 2 (output arbitration), one (N*V):1 arbiter per output VC:
  - Arbitrates among the input VCs whose stage-1 pick is that output VC.
  - The winner receives vc_granted = 1 and sel_out_vc = the picked one-hot VC.
- Latency:
  - The grant is combinational in the same cycle as the request; zero-cycle, required by the non-pipelined controller.
  - ovc_busy and the owner register update on the next rising edge.
- Pointer update (iSLIP-style):
  - Stage-1 and stage-2 pointers advance to one past the granted index only when a final grant occurs. Losing stage-1 picks do not move their pointer.
  - Pointer wrap-around: index V-1 wraps to 0, and index N*V-1 wraps to 0.
- Release:
  - release[o] with ovc_busy[o] = 1 clears busy and owner on the next edge.
  - release[o] with ovc_busy[o] = 0 is ignored; no error.
- Simultaneous release and request on the same output VC:
  - Allocation uses the registered busy flag, so the VC is not granted that cycle.
  - It becomes allocatable the following cycle. Same-cycle re-allocation is therefore impossible by construction.
- No eligible VC: all candidates busy gives no grant. The request must be held by the requester; there is no internal queueing.
- Grants are one-hot per input VC, and at most one grant exists per output VC per cycle.
- Requests that keep asserting after a grant are gated by busy, so no duplicate grant is possible.

Decomposition:
- Shared package/defines: `N, `V, port index constants (LOCAL, E, S, W, N), helper macros for flattened slice indexing.
- One natural sub-module: rr_arbiter, parameterised width W.
  - Inputs: req[W], advance.
  - Outputs: one-hot grant[W].
  - Holds a registered pointer; async active-low reset; pointer advances to grant+1 mod W when advance = 1.
- Instantiated N*V times with W = V (stage 1) and N*V times with W = N*V (stage 2).

Test Plan:
- Single request: after reset, input VC 0 requests port 2, req_vc = 4'b0011 → vc_granted[0] = 1 the same cycle, sel_out_vc[0] = 4'b0001. ovc_busy[8] = 1 next cycle.
- Contention: input VCs 4 and 12 both request port 1 with req_vc = 4'b0001.
  - Cycle 1: VC 4 granted, VC 12 not granted.
  - Next cycle: no grant while ovc_busy[4] = 1.
  - release[4] pulse, then the next cycle after that: VC 12 granted.
- Round-robin fairness: three inputs repeatedly request port 3 VC0, with release asserted each grant → grants rotate in order 0, 4, 8, 0. No input is granted twice before the others.
- Release/request collision: ovc_busy[8] = 1; release[8] and a new request for port 2 VC0 in the same cycle → no grant that cycle, grant in the following cycle.
- Malformed request and reset: req_port = 5'b00110 with req_vc != 0 → no grant, err_req = 1 next cycle. Assert rstn low mid-operation → all busy, err_req and pointers return to 0 asynchronously.
- Full load: all 20 input VCs request distinct output VCs with req_vc = 4'b1111 → every request eventually granted, no output VC granted twice while busy, and a one-hot check on sel_out_vc passes every cycle.
